// File: rtl/buffer_arbiter.sv
// buffer_arbiter: shares the single write port of the buffer between two
// requesters with round-robin arbitration and a bounded burst length, tracks
// buffer occupancy with a credit counter, and drives the buffer read strobe
// from the downstream valid/ready handshake.
//
// Optional build macro BUFFER_ARB_STATS_EN adds per-requester saturating
// accepted-beat counters on ports stat0/stat1.
module buffer_arbiter #(
    parameter int N         = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [N-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [N-1:0]  req1_data,
    output logic          req1_ready,
    output logic          buf_wr_en,
    output logic [N-1:0]  buf_wr_data,
    output logic          buf_rd_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count
`ifdef BUFFER_ARB_STATS_EN
    ,
    output logic [15:0]   stat0,
    output logic [15:0]   stat1
`endif
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          last_grant, last_grant_nxt;
    logic [BW-1:0] burst_cnt, burst_cnt_nxt;

    logic [CW:0]   occ_pend;
    logic          space_ok;
    logic          acc0, acc1;

    logic          vld_p0;
    logic [N-1:0]  data_p0;
    logic          vld_p1;
    logic [N-1:0]  data_p1;

    // Burst counter step that saturates at the last allowed beat index.
    function automatic logic [BW-1:0] burst_step(input logic [BW-1:0] cnt);
        if (cnt == BURST_LAST)
            return cnt;
        return cnt + BW'(1);
    endfunction

    // Occupancy update: a write and a read in the same cycle cancel out.
    function automatic logic [CW-1:0] occ_next(input logic [CW-1:0] occ,
                                               input logic wr,
                                               input logic rd);
        case ({wr, rd})
            2'b10:   return occ + CW'(1);
            2'b01:   return occ - CW'(1);
            default: return occ;
        endcase
    endfunction

    // The in-flight registered write already owns a slot, so it is counted
    // as a credit before a new beat is admitted.
    assign occ_pend   = {1'b0, count} + {{CW{1'b0}}, buf_wr_en};
    assign space_ok   = occ_pend < (CW + 1)'(DEPTH);
    assign req0_ready = (state == GNT0) && space_ok;
    assign req1_ready = (state == GNT1) && space_ok;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    assign out_valid  = (count != '0);
    assign buf_rd_en  = out_valid && out_ready;

    // Arbitration next-state: round robin on ties, burst limit only while the
    // other requester is waiting.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        burst_cnt_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid)
                    state_nxt = last_grant ? GNT0 : GNT1;
                else if (req0_valid)
                    state_nxt = GNT0;
                else if (req1_valid)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (!req0_valid) begin
                    state_nxt      = req1_valid ? GNT1 : IDLE;
                    burst_cnt_nxt  = '0;
                    last_grant_nxt = 1'b0;
                end else if (acc0 && (burst_cnt == BURST_LAST) && req1_valid) begin
                    state_nxt      = GNT1;
                    burst_cnt_nxt  = '0;
                    last_grant_nxt = 1'b0;
                end else if (acc0) begin
                    burst_cnt_nxt  = burst_step(burst_cnt);
                end
            end
            GNT1: begin
                if (!req1_valid) begin
                    state_nxt      = req0_valid ? GNT0 : IDLE;
                    burst_cnt_nxt  = '0;
                    last_grant_nxt = 1'b1;
                end else if (acc1 && (burst_cnt == BURST_LAST) && req0_valid) begin
                    state_nxt      = GNT0;
                    burst_cnt_nxt  = '0;
                    last_grant_nxt = 1'b1;
                end else if (acc1) begin
                    burst_cnt_nxt  = burst_step(burst_cnt);
                end
            end
            default: begin
                state_nxt     = IDLE;
                burst_cnt_nxt = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    // ---- stage p0: accepted beat selected from the granted requester ----
    assign vld_p0  = acc0 || acc1;
    assign data_p0 = acc0 ? req0_data : req1_data;

    // ---- stage p1: registered buffer write; a pending write is dropped on reset ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0)
                data_p1 <= data_p0;
        end
    end

    assign buf_wr_en   = vld_p1;
    assign buf_wr_data = data_p1;

    // Committed occupancy: counts a beat when its write strobe fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else
            count <= occ_next(count, buf_wr_en, buf_rd_en);
    end

`ifdef BUFFER_ARB_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF)
            return v;
        return v + 16'd1;
    endfunction

    // Accepted-beat statistics per requester, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat0 <= '0;
            stat1 <= '0;
        end else begin
            if (acc0)
                stat0 <= sat_inc16(stat0);
            if (acc1)
                stat1 <= sat_inc16(stat1);
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
